xdma_dsc_byp_issuer: RTL

XDMA_DSC_BYP_ISSUER -- requirements
Module: xdma_dsc_byp_issuer

---
 rtl/xdma_dsc_byp_issuer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/xdma_dsc_byp_issuer.sv
// Splits host transfer requests into XDMA descriptor-bypass descriptors and issues them one at a time.
// Optional 4K-style boundary splitting is enabled by defining XDMA_DSC_BOUNDARY_SPLIT_EN.
module xdma_dsc_byp_issuer #(
    parameter int HOST_IS_SRC   = 1,
    parameter int MAX_DSC_BYTES = 4096
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_src_addr,
    input  logic [63:0] req_dst_addr,
    input  logic [27:0] req_len,
    output logic        dsc_byp_load,
    output logic [63:0] dsc_byp_src_addr,
    output logic [63:0] dsc_byp_dst_addr,
    output logic [27:0] dsc_byp_len,
    output logic [15:0] dsc_byp_ctl,
    input  logic        dsc_byp_ready,
    output logic        busy,
    output logic        err_zero_len,
    output logic [15:0] dsc_count,
    output logic [1:0]  dbg_state
);

`ifdef XDMA_DSC_BOUNDARY_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif
    localparam int OFF_W = $clog2(MAX_DSC_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ISSUE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        armed_q;
    logic        err_q;
    logic        last_q;
    logic [63:0] src_q, dst_q;
    logic [27:0] rem_q, chunk_q;
    logic [15:0] count_q;

    logic        accept, xfer;
    logic [OFF_W-1:0] host_off;
    logic [27:0] room, chunk_calc;

    // Handshake: a request moves on the edge where req_valid && req_ready; a
    // descriptor moves on the edge where dsc_byp_load && dsc_byp_ready.
    assign accept = req_valid && req_ready;
    assign xfer   = dsc_byp_load && dsc_byp_ready;

    // Bytes left before the host-side address crosses a MAX_DSC_BYTES boundary.
    always_comb begin
        host_off   = (HOST_IS_SRC != 0) ? src_q[OFF_W-1:0] : dst_q[OFF_W-1:0];
        room       = 28'(MAX_DSC_BYTES) - 28'(host_off);
        chunk_calc = (SPLIT_EN && (room < rem_q)) ? room : rem_q;
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && (req_len != 28'd0)) state_d = S_CALC;
            S_CALC:  state_d = S_ISSUE;
            S_ISSUE: if (xfer) state_d = (rem_q != chunk_q) ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (state_q == S_IDLE) && armed_q;
        dsc_byp_load = (state_q == S_ISSUE);
        busy         = (state_q != S_IDLE);
        dbg_state    = state_q;
    end

    // armed_q holds req_ready low until the first clock edge out of reset.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            armed_q <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            chunk_q <= '0;
            count_q <= '0;
        end else begin
            armed_q <= 1'b1;
            err_q   <= accept && (req_len == 28'd0);
            if (accept && (req_len != 28'd0)) begin
                src_q <= req_src_addr;
                dst_q <= req_dst_addr;
                rem_q <= req_len;
            end
            if (state_q == S_CALC) begin
                chunk_q <= chunk_calc;
                last_q  <= (chunk_calc == rem_q);
            end
            if (xfer) begin
                src_q   <= src_q + {36'd0, chunk_q};
                dst_q   <= dst_q + {36'd0, chunk_q};
                rem_q   <= rem_q - chunk_q;
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign dsc_byp_src_addr = src_q;
    assign dsc_byp_dst_addr = dst_q;
    assign dsc_byp_len      = chunk_q;
    assign dsc_byp_ctl      = {11'd0, last_q, 2'b00, last_q, 1'b0};
    assign err_zero_len     = err_q;
    assign dsc_count        = count_q;

endmodule
